serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 157 +++++++++++++++
 tb/tb_serial_adder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell plus a carry flop produce A + B + Cin
// over WIDTH cycles, LSB first, with registered S/Cout and busy/done status.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           next_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] s_sh_r;
  logic             c_q_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] s_r;
  logic             cout_r;
  logic             busy_r;
  logic             done_r;
  logic             busy_s;
  logic             done_s;
  logic             fa_s_s;
  logic             fa_cout_s;
  logic [WIDTH-1:0] s_next_s;

  full_adder u_fa (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .cin  (c_q_r),
    .s    (fa_s_s),
    .cout (fa_cout_s)
  );

  // New sum bit enters at the MSB so the LSB-first result ends up aligned.
  assign s_next_s = WIDTH'({fa_s_s, s_sh_r} >> 1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic; start is only honoured outside RUN
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_s = RUN;
        else       next_s = IDLE;
      end
      RUN: begin
        if (cnt_r == LAST) next_s = DONE;
        else               next_s = RUN;
      end
      DONE: begin
        if (start) next_s = RUN;
        else       next_s = IDLE;
      end
      default: next_s = IDLE;
    endcase
  end

  // Status decoded from the upcoming state so busy/done come straight from flops
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (next_s)
      RUN:     busy_s = 1'b1;
      DONE:    done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Operand shifters, carry, bit counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r <= {WIDTH{1'b0}};
      b_sh_r <= {WIDTH{1'b0}};
      s_sh_r <= {WIDTH{1'b0}};
      c_q_r  <= 1'b0;
      cnt_r  <= {CW{1'b0}};
      s_r    <= {WIDTH{1'b0}};
      cout_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            a_sh_r <= A;
            b_sh_r <= B;
            c_q_r  <= Cin;
            cnt_r  <= {CW{1'b0}};
            s_sh_r <= {WIDTH{1'b0}};
          end
        end
        RUN: begin
          a_sh_r <= a_sh_r >> 1;
          b_sh_r <= b_sh_r >> 1;
          s_sh_r <= s_next_s;
          c_q_r  <= fa_cout_s;
          cnt_r  <= cnt_r + CW'(1);
          if (cnt_r == LAST) begin
            s_r    <= s_next_s;
            cout_r <= fa_cout_s;
          end
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign S    = s_r;
  assign Cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8 plus a WIDTH=1 instance).

module tb_serial_adder;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] s;
  logic       cout;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       cin1;
  logic       busy1;
  logic       done1;
  logic [0:0] s1;
  logic       cout1;

  int errors = 0;
  int checks = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .Cin(cin),
    .busy(busy), .done(done), .S(s), .Cout(cout)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .Cin(cin1),
    .busy(busy1), .done(done1), .S(s1), .Cout(cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a request for one edge; returns one cycle into RUN.
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    start = 1'b1; a = av; b = bv; cin = cv;
    step();
    start = 1'b0;
  endtask

  // Wait (bounded) for done; returns in the done cycle.
  task automatic wait_done(output int busy_cnt, output bit got);
    busy_cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (s !== 8'h00) begin errors++; $display("FAIL reset_s: got %h want 00", s); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", cout); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int  bc;
    bit  got;
    start_op(8'h5A, 8'h33, 1'b0);
    wait_done(bc, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", got); end
    checks++; if (bc != 8) begin errors++; $display("FAIL basic_busy_len: got %0d want 8", bc); end
    checks++; if (s !== 8'h8D) begin errors++; $display("FAIL basic_s: got %h want 8d", s); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL basic_cout: got %b want 0", cout); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_carry();
    int bc;
    bit got;
    start_op(8'hFF, 8'h01, 1'b0);
    wait_done(bc, got);
    checks++; if (got !== 1'b1 || s !== 8'h00 || cout !== 1'b1) begin
      errors++; $display("FAIL carry_ripple: got done=%b s=%h cout=%b want 1 00 1", got, s, cout); end
    start_op(8'hFF, 8'hFF, 1'b1);
    wait_done(bc, got);
    checks++; if (got !== 1'b1 || s !== 8'hFF || cout !== 1'b1) begin
      errors++; $display("FAIL carry_max: got done=%b s=%h cout=%b want 1 ff 1", got, s, cout); end
    start_op(8'h00, 8'h00, 1'b0);
    wait_done(bc, got);
    checks++; if (got !== 1'b1 || s !== 8'h00 || cout !== 1'b0) begin
      errors++; $display("FAIL carry_zero: got done=%b s=%h cout=%b want 1 00 0", got, s, cout); end
    step();
  endtask

  task automatic test_ignore_start();
    int bc;
    bit got;
    start_op(8'h10, 8'h01, 1'b0);
    bc = 0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) bc++;
      if (bc == 3) begin
        start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    checks++; if (got !== 1'b1 || s !== 8'h11 || cout !== 1'b0) begin
      errors++; $display("FAIL ignore_result: got done=%b s=%h cout=%b want 1 11 0", got, s, cout); end
    checks++; if (bc != 8) begin errors++; $display("FAIL ignore_busy_len: got %0d want 8", bc); end
    step();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL ignore_not_queued: got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_reset_mid_run();
    int bc;
    start_op(8'h0F, 8'h0F, 1'b0);
    bc = 1;
    while (bc < 4) begin
      step();
      bc++;
    end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || s !== 8'h00 || cout !== 1'b0) begin
      errors++; $display("FAIL midrun_reset: got busy=%b done=%b s=%h cout=%b want 0 0 00 0", busy, done, s, cout); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || s !== 8'h00) begin
      errors++; $display("FAIL midrun_idle: got busy=%b done=%b s=%h want 0 0 00", busy, done, s); end
  endtask

  task automatic test_back_to_back();
    int bc;
    int edges;
    bit got;
    bit hold_ok;
    start_op(8'h01, 8'h02, 1'b0);
    wait_done(bc, got);
    checks++; if (got !== 1'b1 || s !== 8'h03 || cout !== 1'b0) begin
      errors++; $display("FAIL b2b_first: got done=%b s=%h cout=%b want 1 03 0", got, s, cout); end
    start_op(8'h80, 8'h80, 1'b1);
    edges = 1;
    hold_ok = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (s !== 8'h03 || busy !== 1'b1) hold_ok = 1'b0;
      step();
      edges++;
    end
    checks++; if (hold_ok !== 1'b1) begin errors++; $display("FAIL b2b_hold: got 0 want 1 (S held 03, busy high)"); end
    checks++; if (got !== 1'b1 || edges != 9) begin
      errors++; $display("FAIL b2b_latency: got done=%b edges=%0d want 1 9", got, edges); end
    checks++; if (s !== 8'h01 || cout !== 1'b1) begin
      errors++; $display("FAIL b2b_second: got s=%h cout=%b want 01 1", s, cout); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_width1();
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    step();
    start1 = 1'b0;
    checks++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      errors++; $display("FAIL w1_run: got busy=%b done=%b want 1 0", busy1, done1); end
    step();
    checks++; if (busy1 !== 1'b0 || done1 !== 1'b1 || s1 !== 1'b1 || cout1 !== 1'b1) begin
      errors++; $display("FAIL w1_result: got busy=%b done=%b s=%b cout=%b want 0 1 1 1", busy1, done1, s1, cout1); end
    step();
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL w1_done_pulse: got %b want 0", done1); end
  endtask

  initial begin
    start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_width1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
